// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the single-port FIFO scheduler.
//   grant_e         : per-cycle arbitration result (none / enqueue / dequeue)
//   OB_DEPTH        : output buffer depth; sized to cover the 1-cycle FIFO read latency
//   RST_SYNC_STAGES : flops in the FIFO reset deassertion synchronizer
package fifo_sched_pkg;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_ENQ,
      GNT_DEQ
   } grant_e;

   localparam int unsigned OB_DEPTH        = 2;
   localparam int unsigned RST_SYNC_STAGES = 2;

endpackage

// File: rtl/fifo_sched_out_buf.sv
// Two-entry registered output buffer that absorbs FIFO read data for the consumer.
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   wr_v_i, wr_data_i   : write one element at the tail
//   v_o, data_o         : head element valid / data
//   yumi_i              : consumer takes the head this cycle (only legal when v_o=1)
//   count_o             : number of stored elements (0..2)
module fifo_sched_out_buf
   import fifo_sched_pkg::*;
#(
   parameter int unsigned width_p = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               wr_v_i,
   input  logic [width_p-1:0] wr_data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i,
   output logic [1:0]         count_o
);

   logic [width_p-1:0] mem_q [OB_DEPTH];
   // Depth is 2, so a single bit pointer wraps naturally by inversion.
   logic               rd_ptr_q, wr_ptr_q;
   logic [1:0]         cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      case ({wr_v_i, yumi_i})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (wr_v_i) wr_ptr_q <= ~wr_ptr_q;
         if (yumi_i) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // Storage needs no reset; validity is carried by cnt_q.
   always_ff @(posedge clk_i) begin
      if (wr_v_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign v_o     = (cnt_q != 2'd0);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

   // Credit accounting upstream must never overfill the buffer; consumer must not over-pop.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(wr_v_i && !yumi_i && cnt_q == 2'(OB_DEPTH)));
         assert (!(yumi_i && cnt_q == 2'd0));
      end
   end

endmodule

// File: rtl/fifo_1rw_scheduler.sv
// Scheduler in front of a single-ported FIFO (one enqueue or one dequeue per cycle).
// Merges a producer valid/ready port and a consumer valid/yumi port into one FIFO
// command stream, with bounded enqueue runs and a 2-entry output buffer that hides
// the 1-cycle FIFO read latency. Also produces the FIFO's synchronous reset.
// Ports:
//   clk_i, reset_n_i           : clock, asynchronous active-low reset
//   in_v_i, in_data_i          : producer valid / data
//   in_ready_o                 : producer ready (transfer on in_v_i & in_ready_o)
//   out_v_o, out_data_o        : consumer valid / data (output buffer head)
//   out_yumi_i                 : consumer accepts head
//   fifo_reset_o               : active-high FIFO reset, released 2 edges after reset_n_i
//   fifo_v_o                   : FIFO command valid
//   fifo_enq_not_deq_o         : 1 = enqueue, 0 = dequeue
//   fifo_data_o                : enqueue data
//   fifo_full_i, fifo_empty_i  : FIFO status, reflecting all earlier commands
//   fifo_data_i                : read data, valid the cycle after a dequeue
// Build option: FIFO_SCHED_BYPASS_EN lets a producer element skip an empty FIFO and
// land directly in the output buffer.
module fifo_1rw_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int unsigned width_p       = 8,
   parameter int unsigned max_enq_run_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               in_v_i,
   input  logic [width_p-1:0] in_data_i,
   output logic               in_ready_o,
   output logic               out_v_o,
   output logic [width_p-1:0] out_data_o,
   input  logic               out_yumi_i,
   output logic               fifo_reset_o,
   output logic               fifo_v_o,
   output logic               fifo_enq_not_deq_o,
   output logic [width_p-1:0] fifo_data_o,
   input  logic               fifo_full_i,
   input  logic               fifo_empty_i,
   input  logic [width_p-1:0] fifo_data_i
);

   localparam int unsigned RunW = $clog2(max_enq_run_p + 1);

   logic [RST_SYNC_STAGES-1:0] rst_sync_q;
   logic                       rd_inflight_q, rd_inflight_d;
   logic [RunW-1:0]            enq_run_q, enq_run_d;
   grant_e                     last_q, last_d;
   grant_e                     grant, grant_eff;
   logic [1:0]                 ob_cnt;
   logic [2:0]                 credit_have, credit_used;
   logic                       enq_ok, deq_ok, starving, run_sat, bypass;
   logic                       ob_wr_v;
   logic [width_p-1:0]         ob_wr_data;

   // FIFO reset asserts asynchronously and deasserts after RST_SYNC_STAGES edges.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rst_sync_q <= '1;
      else            rst_sync_q <= {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b0};
   end
   assign fifo_reset_o = rst_sync_q[RST_SYNC_STAGES-1];

   // Buffer slots not yet spoken for; a same-cycle yumi frees one.
   assign credit_have = 3'd2 + {2'b00, out_yumi_i};
   assign credit_used = {1'b0, ob_cnt} + {2'b00, rd_inflight_q};

   assign enq_ok   = in_v_i & ~fifo_full_i & ~fifo_reset_o;
   assign deq_ok   = ~fifo_empty_i & (credit_have > credit_used) & ~fifo_reset_o;
   assign starving = (ob_cnt == 2'd0) & ~rd_inflight_q;
   assign run_sat  = (enq_run_q == RunW'(max_enq_run_p));

   always_comb begin
      grant = GNT_NONE;
      if (enq_ok && deq_ok) begin
         if (starving || run_sat) grant = GNT_DEQ;
         else                     grant = (last_q == GNT_ENQ) ? GNT_DEQ : GNT_ENQ;
      end else if (enq_ok) begin
         grant = GNT_ENQ;
      end else if (deq_ok) begin
         grant = GNT_DEQ;
      end
   end

`ifdef FIFO_SCHED_BYPASS_EN
   // Nothing queued ahead of the producer: hand its element straight to the buffer.
   assign bypass = in_v_i & fifo_empty_i & ~rd_inflight_q & (ob_cnt == 2'd0) &
                   (grant != GNT_DEQ) & ~fifo_reset_o;
`else
   assign bypass = 1'b0;
`endif

   assign grant_eff = bypass ? GNT_NONE : grant;

   assign in_ready_o         = (grant_eff == GNT_ENQ) | bypass;
   assign fifo_v_o           = (grant_eff != GNT_NONE);
   assign fifo_enq_not_deq_o = (grant_eff == GNT_ENQ);
   assign fifo_data_o        = in_data_i;

   always_comb begin
      rd_inflight_d = (grant_eff == GNT_DEQ);
      last_d        = (grant_eff == GNT_NONE) ? last_q : grant_eff;
      enq_run_d     = enq_run_q;
      // Run only counts while a dequeue was actually being held off.
      if (!deq_ok || grant_eff == GNT_DEQ) begin
         enq_run_d = '0;
      end else if (grant_eff == GNT_ENQ && !run_sat) begin
         enq_run_d = enq_run_q + RunW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_inflight_q <= 1'b0;
         enq_run_q     <= '0;
         last_q        <= GNT_NONE;
      end else begin
         rd_inflight_q <= rd_inflight_d;
         enq_run_q     <= enq_run_d;
         last_q        <= last_d;
      end
   end

   assign ob_wr_v    = rd_inflight_q | bypass;
   assign ob_wr_data = rd_inflight_q ? fifo_data_i : in_data_i;

   fifo_sched_out_buf #(
      .width_p (width_p)
   ) u_out_buf (
      .clk_i     (clk_i),
      .rst_ni    (reset_n_i),
      .wr_v_i    (ob_wr_v),
      .wr_data_i (ob_wr_data),
      .v_o       (out_v_o),
      .data_o    (out_data_o),
      .yumi_i    (out_yumi_i),
      .count_o   (ob_cnt)
   );

endmodule

// File: tb/tb_fifo_1rw_scheduler.sv
// Self-checking bench for fifo_1rw_scheduler with a behavioural single-port FIFO model
// and a scoreboard of producer transfers checked against consumer pops.
module tb_fifo_1rw_scheduler;

   localparam int unsigned Width   = 8;
   localparam int unsigned MaxRun  = 4;
   localparam int unsigned FifoCap = 16;
`ifdef FIFO_SCHED_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic             clk_i = 1'b0;
   logic             reset_n_i;
   logic             in_v_i;
   logic [Width-1:0] in_data_i;
   logic             in_ready_o;
   logic             out_v_o;
   logic [Width-1:0] out_data_o;
   logic             out_yumi_i;
   logic             fifo_reset_o;
   logic             fifo_v_o;
   logic             fifo_enq_not_deq_o;
   logic [Width-1:0] fifo_data_o;
   logic             fifo_full_i;
   logic             fifo_empty_i;
   logic [Width-1:0] fifo_data_i;

   logic             yumi_en;
   logic             full_force;
   logic             track_en;

   always #5 clk_i = ~clk_i;

   fifo_1rw_scheduler #(
      .width_p       (Width),
      .max_enq_run_p (MaxRun)
   ) dut (
      .clk_i              (clk_i),
      .reset_n_i          (reset_n_i),
      .in_v_i             (in_v_i),
      .in_data_i          (in_data_i),
      .in_ready_o         (in_ready_o),
      .out_v_o            (out_v_o),
      .out_data_o         (out_data_o),
      .out_yumi_i         (out_yumi_i),
      .fifo_reset_o       (fifo_reset_o),
      .fifo_v_o           (fifo_v_o),
      .fifo_enq_not_deq_o (fifo_enq_not_deq_o),
      .fifo_data_o        (fifo_data_o),
      .fifo_full_i        (fifo_full_i),
      .fifo_empty_i       (fifo_empty_i),
      .fifo_data_i        (fifo_data_i)
   );

   assign out_yumi_i = yumi_en & out_v_o;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- FIFO model ----------------
   logic [Width-1:0] mq [$];
   int               mcount = 0;
   logic             cmd_v = 1'b0, cmd_enq = 1'b0, cmd_rst = 1'b1;
   logic [Width-1:0] cmd_data = '0;

   assign fifo_full_i  = (mcount >= FifoCap) | full_force;
   assign fifo_empty_i = (mcount == 0);

   initial fifo_data_i = '0;

   always @(posedge clk_i) begin
      #1;
      if (cmd_rst) begin
         mq.delete();
         mcount = 0;
      end else if (cmd_v) begin
         if (cmd_enq) begin
            mq.push_back(cmd_data);
            mcount++;
         end else if (mq.size() > 0) begin
            fifo_data_i = mq.pop_front();
            mcount--;
         end
      end
   end

   // ---------------- Monitor / scoreboard ----------------
   logic [Width-1:0] exp_q [$];
   int               deq_cnt = 0;
   int               run = 0;
   int               max_run = 0;

   always @(negedge clk_i) begin
      cmd_v    = fifo_v_o;
      cmd_enq  = fifo_enq_not_deq_o;
      cmd_data = fifo_data_o;
      cmd_rst  = fifo_reset_o;
      if (in_v_i && in_ready_o) exp_q.push_back(in_data_i);
      if (out_v_o && out_yumi_i) begin
         if (exp_q.size() == 0) check("sb_unexpected_out", 32'(out_data_o), 32'hFFFF_FFFF);
         else                   check("sb_data", 32'(out_data_o), 32'(exp_q.pop_front()));
      end
      if (fifo_v_o && !fifo_enq_not_deq_o) deq_cnt++;
      if (track_en) begin
         if (fifo_v_o && fifo_enq_not_deq_o && !fifo_empty_i) begin
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
      end
   end

   // ---------------- Helpers ----------------
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // Called just after a rising edge; returns just after the edge that took the element.
   task automatic send(input logic [Width-1:0] d);
      int n = 0;
      in_v_i    = 1'b1;
      in_data_i = d;
      @(negedge clk_i);
      while (!in_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (!in_ready_o) check("send_timeout", 32'(in_ready_o), 32'd1);
      cyc();
      in_v_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      yumi_en = 1'b1;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (4) @(negedge clk_i);
      check("drain_idle_out_v", 32'(out_v_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- Stimulus ----------------
   initial begin
      logic [3:0] fv_exp, ov_exp;
      logic       got;
      int         n;

      reset_n_i  = 1'b0;
      in_v_i     = 1'b1;
      in_data_i  = 8'h11;
      yumi_en    = 1'b0;
      full_force = 1'b0;
      track_en   = 1'b0;

      // Reset held: everything quiet even with a valid producer.
      repeat (3) begin
         @(negedge clk_i);
         check("rst_fifo_reset", 32'(fifo_reset_o), 32'd1);
         check("rst_in_ready", 32'(in_ready_o), 32'd0);
         check("rst_out_v", 32'(out_v_o), 32'd0);
         check("rst_fifo_v", 32'(fifo_v_o), 32'd0);
      end
      cyc();
      reset_n_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         check("rel_fifo_reset", 32'(fifo_reset_o), 32'd1);
         check("rel_in_ready", 32'(in_ready_o), 32'd0);
         check("rel_fifo_v", 32'(fifo_v_o), 32'd0);
         cyc();
      end
      in_v_i = 1'b0;
      @(negedge clk_i);
      check("rel_fifo_reset_done", 32'(fifo_reset_o), 32'd0);

      // Single element latency.
      fv_exp = Byp ? 4'b0000 : 4'b0011;
      ov_exp = Byp ? 4'b0010 : 4'b1000;
      cyc();
      yumi_en   = 1'b1;
      in_v_i    = 1'b1;
      in_data_i = 8'hA5;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         if (k == 0) check("single_ready", 32'(in_ready_o), 32'd1);
         check("single_fifo_v", 32'(fifo_v_o), 32'(fv_exp[k]));
         check("single_out_v", 32'(out_v_o), 32'(ov_exp[k]));
         if (ov_exp[k]) check("single_out_data", 32'(out_data_o), 32'hA5);
         if (fv_exp[k] && k == 1) check("single_is_deq", 32'(fifo_enq_not_deq_o), 32'd0);
         cyc();
         in_v_i = 1'b0;
      end
      drain();

      // Backpressure: buffer fills, dequeues stop until the consumer pops.
      cyc();
      yumi_en = 1'b0;
      deq_cnt = 0;
      for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
      repeat (8) cyc();
      @(negedge clk_i);
      check("bp_deq_cnt", 32'(deq_cnt), Byp ? 32'd1 : 32'd2);
      check("bp_out_v", 32'(out_v_o), 32'd1);
      drain();

      // Enqueue-run bound with a deep FIFO, streaming producer and eager consumer.
      cyc();
      yumi_en = 1'b0;
      for (int i = 0; i < 12; i++) send(8'(i));
      yumi_en  = 1'b1;
      run      = 0;
      max_run  = 0;
      track_en = 1'b1;
      for (int i = 0; i < 100; i++) send(8'(8'h40 + i));
      track_en = 1'b0;
      drain();
      check("starve_run_bound", 32'(max_run <= MaxRun), 32'd1);

      // FIFO full: no enqueue, dequeues continue, ready returns once full drops.
      cyc();
      yumi_en = 1'b0;
      for (int i = 0; i < 8; i++) send(8'(8'h90 + i));
      yumi_en    = 1'b1;
      full_force = 1'b1;
      deq_cnt    = 0;
      in_v_i     = 1'b1;
      in_data_i  = 8'h77;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         check("full_in_ready", 32'(in_ready_o), 32'd0);
         if (fifo_v_o) check("full_cmd_is_deq", 32'(fifo_enq_not_deq_o), 32'd0);
         cyc();
      end
      check("full_deq_seen", 32'(deq_cnt > 0), 32'd1);
      full_force = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 2 && !got; k++) begin
         @(negedge clk_i);
         got = in_ready_o;
         if (!got) cyc();
      end
      check("full_release_ready", 32'(got), 32'd1);
      cyc();
      in_v_i = 1'b0;
      drain();

      // Reset in the middle of a read.
      cyc();
      yumi_en = 1'b0;
      for (int i = 0; i < 4; i++) send(8'(8'hC0 + i));
      yumi_en = 1'b1;
      got = 1'b0;
      n   = 0;
      while (!got && n < 50) begin
         @(negedge clk_i);
         got = fifo_v_o & ~fifo_enq_not_deq_o;
         n++;
         if (!got) cyc();
      end
      check("mrst_deq_found", 32'(got), 32'd1);
      cyc();
      reset_n_i = 1'b0;
      exp_q.delete();
      #1;
      check("mrst_out_v", 32'(out_v_o), 32'd0);
      check("mrst_fifo_reset", 32'(fifo_reset_o), 32'd1);
      check("mrst_in_ready", 32'(in_ready_o), 32'd0);
      repeat (2) cyc();
      reset_n_i = 1'b1;
      repeat (4) cyc();
      for (int i = 1; i <= 3; i++) send(8'(i));
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
